cam_cfg_sequencer: RTL and testbench
====================================

CAM_CFG_SEQUENCER -- requirements
Module: cam_cfg_sequencer

Interface
REQ-001 Parameter IDX_W, 8: width of the table index; table depth is 2**IDX_W entries per mode.
REQ-002 Parameter NUM_MODES, 2: number of register tables (mode 0 = VGA YUV422, mode 1 = QVGA RGB565); at least 1.
REQ-003 Parameter DELAY_UNIT, 50000: CLK cycles per delay tick (1 ms at 50 MHz); at least 1.
REQ-004 Parameter MAX_RETRY, 3: NACK retries per entry before error; 0 to 15.
REQ-005 CLK  in  1  sole clock; reset is synchronous and active-high.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 START  in  1  single-cycle request to run the table selected by MODE.
REQ-008 MODE  in  $clog2(NUM_MODES) (min 1)  table select; sampled only when START is accepted.
REQ-009 CMD_VALID/CMD_READY  out/in  1/1  valid/ready command handshake to the SCCB master.
REQ-010 CMD_RW  out  1  0 = write, 1 = read.
REQ-011 CMD_ADDR, CMD_WDATA  out  8 each  register address and write data.
REQ-012 RSP_VALID  in  1  one-cycle completion pulse from the SCCB master.
REQ-013 RSP_NACK  in  1  slave NACK; qualified by RSP_VALID.
REQ-014 RSP_RDATA  in  8  read data; qualified by RSP_VALID.
REQ-015 BUSY, DONE, ERR  out  1 each  status flags.
REQ-016 ERR_INDEX  out  IDX_W  index of the failing entry.
REQ-017 PROGRESS  out  IDX_W  index of the entry currently being executed.

Function
REQ-018 Table entry format: 16 bits, {addr[15:8], data[7:0]}.
REQ-019 Entry 16'hFFFF is the end marker.
REQ-020 An entry with addr 8'hFE is a delay of data x DELAY_UNIT cycles; data 0 means no wait.
REQ-021 The FSM states are IDLE, FETCH, ISSUE, WAIT_RSP, DELAY, VERIFY, DONE, ERROR.
REQ-022 START in IDLE, DONE or ERROR latches MODE, clears the index, DONE and ERR, and enters FETCH on the next cycle.
REQ-023 START in any other state is ignored.
REQ-024 FETCH lasts 1 cycle (registered table read), then routes by entry type.
REQ-025 End marker goes to DONE; delay entry goes to DELAY; any other entry goes to ISSUE.
REQ-026 ISSUE asserts CMD_VALID with CMD_RW, CMD_ADDR and CMD_WDATA held stable until the cycle CMD_READY=1.
REQ-027 After that handshake cycle the FSM enters WAIT_RSP.
REQ-028 In WAIT_RSP, RSP_VALID with NACK=0 increments the index and returns to FETCH.
REQ-029 In WAIT_RSP, RSP_VALID with NACK=1 increments the retry count and re-enters ISSUE while the count is at most MAX_RETRY; otherwise the FSM enters ERROR.
REQ-030 The retry count clears at every index advance.
REQ-031 RSP_VALID outside WAIT_RSP and VERIFY is ignored.
REQ-032 The index saturates: reaching 2**IDX_W-1 without an end marker ends in DONE after that entry executes; it never wraps.
REQ-033 BUSY=1 in FETCH, ISSUE, WAIT_RSP, DELAY and VERIFY.
REQ-034 DONE and ERR are levels held until the next accepted START or RST.
REQ-035 ERROR latches ERR_INDEX to the failing index.
REQ-036 Write 16'h1280 (soft reset) as the first entry of every mode table, followed by a delay entry of at least 1 tick.

Reset
REQ-037 RST forces state IDLE; outputs BUSY, DONE, ERR and CMD_VALID go to 0; ERR_INDEX, PROGRESS, CMD_ADDR and CMD_WDATA go to 0; retry count and delay counter go to 0.
REQ-038 RST asserted mid-transaction drops CMD_VALID in the same clock edge.
REQ-039 A later RSP_VALID arriving in IDLE is ignored.

Configuration
REQ-040 Macro CAM_CFG_READBACK_EN: when defined, every successful write is followed by a read (CMD_RW=1) of the same address in state VERIFY.
REQ-041 With CAM_CFG_READBACK_EN, a mismatch between RSP_RDATA and the written data, or a NACK, counts as a retry and restarts the write.
REQ-042 With CAM_CFG_READBACK_EN, writes to addr 8'h12 skip verification.
REQ-043 Without the macro, VERIFY is unreachable and no read command is ever issued.

Structure
REQ-044 Package cam_cfg_pkg holds: the state enum; the END_MARK (16'hFFFF) and DELAY_ADDR (8'hFE) constants; the entry typedef; the mode index constants.
REQ-045 Sub-module cam_cfg_rom(IDX_W, NUM_MODES) holds the tables as a registered, one-cycle-latency lookup; unused indices return END_MARK.

Verification
REQ-046 Mode 0, table {1280, FE02, 3A0D, FFFF}, DELAY_UNIT=4: START -> writes 12/80; no CMD_VALID for 8 cycles; write 3A/0D; DONE=1; 2 commands total.
REQ-047 CMD_READY held low 5 cycles -> CMD_VALID and its fields stable throughout; exactly one command accepted.
REQ-048 MAX_RETRY=2, slave NACKs entry 2 always -> 3 issues of that entry; ERR=1; ERR_INDEX=2; BUSY=0.
REQ-049 RST pulsed while in WAIT_RSP, then a stray RSP_VALID -> IDLE; all flags 0; no new command.
REQ-050 With CAM_CFG_READBACK_EN, first readback returns 0x0C for a 0x0D write -> write reissued; second readback matches; sequence continues; without the macro, zero reads are issued.
REQ-051 START during BUSY with a different MODE -> ignored; the original table completes.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register-table sequencer.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitRsp,
    StDelay,
    StVerify,
    StDone,
    StError
  } state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  localparam logic [15:0] END_MARK      = 16'hFFFF;
  localparam logic [7:0]  DELAY_ADDR    = 8'hFE;
  localparam logic [7:0]  SOFT_RST_ADDR = 8'h12;

  localparam int MODE_VGA_YUV422  = 0;
  localparam int MODE_QVGA_RGB565 = 1;

endpackage

// File: rtl/cam_cfg_rom.sv
// Register tables, one per mode, read with one cycle of latency.
module cam_cfg_rom
  import cam_cfg_pkg::*;
#(
  parameter int IDX_W     = 8,
  parameter int NUM_MODES = 2,
  localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              i_clk,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [IDX_W-1:0]  i_idx,
  output entry_t            o_entry
);

  entry_t w_entry;
  entry_t r_entry;

  always_comb begin
    w_entry = END_MARK;
    if (int'(i_mode) == MODE_VGA_YUV422) begin
      case (int'(i_idx))
        0:       w_entry = 16'h1280;
        1:       w_entry = 16'hFE02;
        2:       w_entry = 16'h3A0D;
        default: w_entry = END_MARK;
      endcase
    end else if (NUM_MODES > 1 && int'(i_mode) == MODE_QVGA_RGB565) begin
      case (int'(i_idx))
        0:       w_entry = 16'h1280;
        1:       w_entry = 16'hFE01;
        2:       w_entry = 16'h1214;
        3:       w_entry = 16'h40D0;
        4:       w_entry = 16'h8C00;
        default: w_entry = END_MARK;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    r_entry <= w_entry;
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks a per-mode register table and issues SCCB writes, delays and retries.
// Optional readback verification of each write is enabled by CAM_CFG_READBACK_EN.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int IDX_W      = 8,
  parameter int NUM_MODES  = 2,
  parameter int DELAY_UNIT = 50000,
  parameter int MAX_RETRY  = 3,
  localparam int MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [MODE_W-1:0] i_mode,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic              o_cmd_rw,
  output logic [7:0]        o_cmd_addr,
  output logic [7:0]        o_cmd_wdata,
  input  logic              i_rsp_valid,
  input  logic              i_rsp_nack,
  input  logic [7:0]        i_rsp_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [IDX_W-1:0]  o_err_index,
  output logic [IDX_W-1:0]  o_progress
);

  localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
`ifdef CAM_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  state_e            r_state, w_state_n;
  logic [MODE_W-1:0] r_mode, w_mode_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic [IDX_W-1:0]  r_err_index, w_err_index_n;
  logic [3:0]        r_retry, w_retry_n;
  logic [DLY_W-1:0]  r_dly, w_dly_n;
  logic              r_cmd_rw, w_cmd_rw_n;
  logic [7:0]        r_cmd_addr, w_cmd_addr_n;
  logic [7:0]        r_cmd_wdata, w_cmd_wdata_n;
  logic              r_rd_sent, w_rd_sent_n;
  logic [4:0]        w_retry_inc;
  logic              w_advance;
  logic              w_retry_req;
  entry_t            w_entry;

  // Addressed with next-state mode/index so the entry is valid during FETCH.
  cam_cfg_rom #(
    .IDX_W    (IDX_W),
    .NUM_MODES(NUM_MODES)
  ) u_rom (
    .i_clk  (i_clk),
    .i_mode (w_mode_n),
    .i_idx  (w_idx_n),
    .o_entry(w_entry)
  );

  always_comb begin
    w_state_n     = r_state;
    w_mode_n      = r_mode;
    w_idx_n       = r_idx;
    w_err_index_n = r_err_index;
    w_retry_n     = r_retry;
    w_dly_n       = r_dly;
    w_cmd_rw_n    = r_cmd_rw;
    w_cmd_addr_n  = r_cmd_addr;
    w_cmd_wdata_n = r_cmd_wdata;
    w_rd_sent_n   = r_rd_sent;
    w_retry_inc   = {1'b0, r_retry} + 5'd1;
    w_advance     = 1'b0;
    w_retry_req   = 1'b0;
    case (r_state)
      StIdle, StDone, StError: begin
        if (i_start) begin
          w_state_n = StFetch;
          w_mode_n  = i_mode;
          w_idx_n   = '0;
          w_retry_n = '0;
        end
      end
      StFetch: begin
        if (w_entry == END_MARK) begin
          w_state_n = StDone;
        end else if (w_entry.addr == DELAY_ADDR) begin
          w_state_n = StDelay;
          w_dly_n   = DLY_W'(w_entry.data) * DLY_W'(DELAY_UNIT);
        end else begin
          w_state_n     = StIssue;
          w_cmd_rw_n    = 1'b0;
          w_cmd_addr_n  = w_entry.addr;
          w_cmd_wdata_n = w_entry.data;
        end
      end
      StIssue: begin
        if (i_cmd_ready) w_state_n = StWaitRsp;
      end
      StWaitRsp: begin
        if (i_rsp_valid) begin
          if (i_rsp_nack) begin
            w_retry_req = 1'b1;
          end else if (READBACK && r_cmd_addr != SOFT_RST_ADDR) begin
            w_state_n   = StVerify;
            w_cmd_rw_n  = 1'b1;
            w_rd_sent_n = 1'b0;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      StDelay: begin
        if (r_dly <= DLY_W'(1)) w_advance = 1'b1;
        else                    w_dly_n   = r_dly - DLY_W'(1);
      end
      StVerify: begin
        if (!r_rd_sent) begin
          if (i_cmd_ready) w_rd_sent_n = 1'b1;
        end else if (i_rsp_valid) begin
          if (i_rsp_nack || i_rsp_rdata != r_cmd_wdata) w_retry_req = 1'b1;
          else                                          w_advance   = 1'b1;
        end
      end
      default: w_state_n = StIdle;
    endcase

    if (w_retry_req) begin
      w_cmd_rw_n = 1'b0;
      if (w_retry_inc <= 5'(MAX_RETRY)) begin
        w_retry_n = w_retry_inc[3:0];
        w_state_n = StIssue;
      end else begin
        w_state_n     = StError;
        w_err_index_n = r_idx;
      end
    end

    // The last index finishes the run instead of wrapping.
    if (w_advance) begin
      w_retry_n = '0;
      if (r_idx == LAST_IDX) begin
        w_state_n = StDone;
      end else begin
        w_idx_n   = r_idx + IDX_W'(1);
        w_state_n = StFetch;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_mode      <= '0;
      r_idx       <= '0;
      r_err_index <= '0;
      r_retry     <= '0;
      r_dly       <= '0;
      r_cmd_rw    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_rd_sent   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_mode      <= w_mode_n;
      r_idx       <= w_idx_n;
      r_err_index <= w_err_index_n;
      r_retry     <= w_retry_n;
      r_dly       <= w_dly_n;
      r_cmd_rw    <= w_cmd_rw_n;
      r_cmd_addr  <= w_cmd_addr_n;
      r_cmd_wdata <= w_cmd_wdata_n;
      r_rd_sent   <= w_rd_sent_n;
    end
  end

  assign o_cmd_valid = (r_state == StIssue) || (r_state == StVerify && !r_rd_sent);
  assign o_cmd_rw    = r_cmd_rw;
  assign o_cmd_addr  = r_cmd_addr;
  assign o_cmd_wdata = r_cmd_wdata;
  assign o_busy      = (r_state == StFetch) || (r_state == StIssue) || (r_state == StWaitRsp) ||
                       (r_state == StDelay) || (r_state == StVerify);
  assign o_done      = (r_state == StDone);
  assign o_err       = (r_state == StError);
  assign o_err_index = r_err_index;
  assign o_progress  = r_idx;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Self-checking bench for cam_cfg_sequencer: directed vector table plus randomized slave timing
// and NACKs, scored against an entry-level reference model.
module tb_cam_cfg_sequencer;

  localparam int IDX_W      = 2;
  localparam int NUM_MODES  = 2;
  localparam int DELAY_UNIT = 4;
  localparam int MAX_RETRY  = 2;
  localparam int DEPTH      = 1 << IDX_W;
  localparam int BUDGET     = 2000;
`ifdef CAM_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, cmd_ready, rsp_valid, rsp_nack;
  logic [0:0]       mode;
  logic [7:0]       rsp_rdata;
  logic             cmd_valid, cmd_rw, busy, done, err;
  logic [7:0]       cmd_addr, cmd_wdata;
  logic [IDX_W-1:0] err_index, progress;

  always #5 clk = ~clk;

  cam_cfg_sequencer #(
    .IDX_W     (IDX_W),
    .NUM_MODES (NUM_MODES),
    .DELAY_UNIT(DELAY_UNIT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_mode     (mode),
    .o_cmd_valid(cmd_valid),
    .i_cmd_ready(cmd_ready),
    .o_cmd_rw   (cmd_rw),
    .o_cmd_addr (cmd_addr),
    .o_cmd_wdata(cmd_wdata),
    .i_rsp_valid(rsp_valid),
    .i_rsp_nack (rsp_nack),
    .i_rsp_rdata(rsp_rdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_index(err_index),
    .o_progress (progress)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int reads    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference tables, truncated to DEPTH by the model.
  function automatic logic [15:0] ref_entry(input int m, input int i);
    logic [15:0] t0 [4];
    logic [15:0] t1 [6];
    t0 = '{16'h1280, 16'hFE02, 16'h3A0D, 16'hFFFF};
    t1 = '{16'h1280, 16'hFE01, 16'h1214, 16'h40D0, 16'h8C00, 16'hFFFF};
    if (m == 0 && i < 4) return t0[i];
    if (m == 1 && i < 6) return t1[i];
    return 16'hFFFF;
  endfunction

  // Entry-level model: which entry is pending, whether its readback is pending, and outcome.
  int m_mode, m_idx, m_retries, m_status, m_err_idx;
  bit m_verify;

  task automatic m_advance();
    m_retries = 0;
    if (m_idx == DEPTH - 1) m_status = 1;
    else m_idx++;
  endtask

  task automatic m_settle();
    logic [15:0] e;
    bit go;
    go = 1'b1;
    while (go && m_status == 0 && !m_verify) begin
      e = ref_entry(m_mode, m_idx);
      if (e == 16'hFFFF) m_status = 1;
      else if (e[15:8] == 8'hFE) m_advance();
      else go = 1'b0;
    end
  endtask

  task automatic m_fail();
    m_retries++;
    if (m_retries > MAX_RETRY) begin
      m_status  = 2;
      m_err_idx = m_idx;
    end
  endtask

  task automatic m_response(input bit nack, input logic [7:0] rdata);
    logic [15:0] e;
    e = ref_entry(m_mode, m_idx);
    if (!m_verify) begin
      if (nack) m_fail();
      else if (RB && e[15:8] != 8'h12) m_verify = 1'b1;
      else m_advance();
    end else begin
      m_verify = 1'b0;
      if (nack || rdata != e[7:0]) m_fail();
      else m_advance();
    end
    m_settle();
  endtask

  logic [7:0] mem [256];

  // policy: 0 clean, 1 random NACK/corruption, 2 NACK every write of entry 2,
  // 3 corrupt the first readback only.
  task automatic run(input int m, input int policy, input int rdy, input bit inj, input bit rnd,
                     output int n_cmd, output int n_3a, output int gap);
    int cyc, wait_cnt, lat, t_rsp0, n_rsp;
    bit seen, pend, nack, corrupted;
    logic [16:0] hold;
    logic cur_rw;
    logic [7:0] cur_addr, cur_wdata, rd;
    logic [15:0] exp_e;
    n_cmd = 0; n_3a = 0; gap = -1; t_rsp0 = 0; n_rsp = 0;
    seen = 0; pend = 0; corrupted = 0; wait_cnt = 0; lat = 0;
    cur_rw = 0; cur_addr = 0; cur_wdata = 0; hold = '0;
    m_mode = m; m_idx = 0; m_retries = 0; m_verify = 0; m_status = 0; m_err_idx = 0;
    m_settle();
    @(negedge clk);
    start = 1'b1;
    mode  = 1'(m);
    @(negedge clk);
    start = 1'b0;
    check("start_clears_flags", {done, err}, 2'b00);
    check("start_sets_busy", busy, 1'b1);
    cyc = 0;
    while (!(done || err) && cyc < BUDGET) begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (inj && cyc == 3) begin
        start = 1'b1;
        mode  = (m == 0) ? 1'b1 : 1'b0;
      end else begin
        start = 1'b0;
      end
      if (cmd_valid) begin
        check("busy_with_valid", busy, 1'b1);
        if (!seen) begin
          seen = 1'b1;
          hold = {cmd_rw, cmd_addr, cmd_wdata};
          wait_cnt = rnd ? int'($urandom_range(0, 3)) : rdy;
          if (n_cmd == 1 && n_rsp == 1) gap = cyc - t_rsp0 - 1;
        end else begin
          check("fields_stable", {cmd_rw, cmd_addr, cmd_wdata}, hold);
        end
        if (wait_cnt == 0) begin
          cmd_ready = 1'b1;
          seen      = 1'b0;
          n_cmd++;
          cur_rw = cmd_rw; cur_addr = cmd_addr; cur_wdata = cmd_wdata;
          if (cmd_rw) reads++;
          if (!cmd_rw && cmd_addr == 8'h3A) n_3a++;
          exp_e = ref_entry(m_mode, m_idx);
          check("cmd_while_running", m_status, 0);
          check("cmd_rw", cmd_rw, m_verify);
          check("cmd_addr", cmd_addr, exp_e[15:8]);
          if (!cmd_rw) check("cmd_wdata", cmd_wdata, exp_e[7:0]);
          pend = 1'b1;
          lat  = rnd ? int'($urandom_range(0, 3)) : 1;
        end else begin
          wait_cnt--;
        end
      end else if (pend) begin
        if (lat == 0) begin
          pend = 1'b0;
          case (policy)
            1:       nack = ($urandom_range(0, 3) == 0);
            2:       nack = (m_idx == 2 && !m_verify);
            default: nack = 1'b0;
          endcase
          rd = mem[cur_addr];
          if (cur_rw && policy == 3 && !corrupted) begin
            rd = rd - 8'd1;
            corrupted = 1'b1;
          end
          if (cur_rw && policy == 1 && $urandom_range(0, 3) == 0) rd = ~rd;
          if (!cur_rw && !nack) mem[cur_addr] = cur_wdata;
          rsp_valid = 1'b1;
          rsp_nack  = nack;
          rsp_rdata = rd;
          n_rsp++;
          if (n_rsp == 1) t_rsp0 = cyc;
          m_response(nack, rd);
        end else begin
          lat--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
    check("run_finished_in_budget", cyc < BUDGET, 1'b1);
    check("model_done", done, m_status == 1);
    check("model_err", err, m_status == 2);
    if (m_status == 2) check("model_err_index", err_index, m_err_idx);
    check("idle_busy", busy, 1'b0);
    check("idle_cmd_valid", cmd_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("flags_held", {done, err}, {m_status == 1, m_status == 2});
  endtask

  typedef struct {
    int mode;
    int policy;
    int rdy;
    bit inj;
    bit exp_done;
    bit exp_err;
    int exp_err_idx;
    int exp_cmds;
    int exp_3a;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, n_cmd, n_3a, gap;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    vecs[0] = '{0, 0, 0, 1'b0, 1'b1, 1'b0, 0, RB ? 3 : 2, 1};
    vecs[1] = '{0, 0, 5, 1'b0, 1'b1, 1'b0, 0, RB ? 3 : 2, 1};
    vecs[2] = '{0, 2, 0, 1'b0, 1'b0, 1'b1, 2, 4, 3};
    vecs[3] = '{1, 0, 1, 1'b0, 1'b1, 1'b0, 0, RB ? 4 : 3, 0};
    vecs[4] = '{0, 3, 0, 1'b0, 1'b1, 1'b0, 0, RB ? 5 : 2, RB ? 2 : 1};
    vecs[5] = '{0, 0, 0, 1'b1, 1'b1, 1'b0, 0, RB ? 3 : 2, 1};

    rst = 1'b1; start = 1'b0; mode = 1'b0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_flags", {busy, done, err, cmd_valid}, 4'b0000);
    check("rst_err_index", err_index, 0);
    check("rst_progress", progress, 0);
    check("rst_cmd_fields", {cmd_addr, cmd_wdata}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {busy, done, err}, 3'b000);

    for (int v = 0; v < 6; v++) begin
      run(vecs[v].mode, vecs[v].policy, vecs[v].rdy, vecs[v].inj, 1'b0, n_cmd, n_3a, gap);
      check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      if (vecs[v].exp_err) check($sformatf("vec%0d_err_index", v), err_index, vecs[v].exp_err_idx);
      check($sformatf("vec%0d_cmds", v), n_cmd, vecs[v].exp_cmds);
      check($sformatf("vec%0d_issues_3a", v), n_3a, vecs[v].exp_3a);
      if (vecs[v].mode == 0) check($sformatf("vec%0d_delay_gap", v), gap >= 2 * DELAY_UNIT, 1'b1);
    end

    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(0, 1)), 1, 0, 1'b0, 1'b1, n_cmd, n_3a, gap);
    end

    check("reads_seen", reads > 0, RB);

    // Reset while a command is being offered.
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!cmd_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_test_valid_seen", cmd_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_drops_valid", cmd_valid, 1'b0);
    check("rst_mid_flags", {busy, done, err}, 3'b000);
    check("rst_mid_progress", progress, 0);
    check("rst_mid_addr", cmd_addr, 8'h00);

    // Reset while waiting for a response, then a stray response.
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!cmd_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("wait_rsp_busy", {busy, cmd_valid}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_nack = 1'b0;
    @(negedge clk);
    rsp_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("stray_rsp_ignored", {busy, done, err, cmd_valid}, 4'b0000);
      @(negedge clk);
    end
    check("stray_rsp_progress", progress, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
